// File: rtl/nv_nvdla_csc_pra_cell_chn_out_wait_mc.sv
// Per-channel early-ack wait counters for the CSC output path; optional sticky
// overflow/underflow flags are built when NVDLA_CSC_CHN_WAIT_ERR_EN is defined.
module nv_nvdla_csc_pra_cell_chn_out_wait_mc #(
   parameter int CHN_NUM   = 4,
   parameter int ACK_DEPTH = 2
) (
   input  logic                              nvdla_core_clk,
   input  logic                              nvdla_core_rstn,
   input  logic [CHN_NUM-1:0]                chn_oswt,
   input  logic [CHN_NUM-1:0]                chn_biwt,
   input  logic [CHN_NUM-1:0]                chn_bdwt,
   input  logic                              grp_bdwt,
   input  logic                              err_clr,
   output logic [CHN_NUM-1:0]                chn_bawt,
   output logic [CHN_NUM-1:0]                chn_wen_comp,
   output logic                              all_bawt,
   output logic [CHN_NUM*$clog2(ACK_DEPTH+1)-1:0] chn_pend_cnt,
   output logic [CHN_NUM-1:0]                chn_err
);

   localparam int CW = $clog2(ACK_DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(ACK_DEPTH);

   logic [CW-1:0]      cnt_q [CHN_NUM];
   logic [CW-1:0]      cnt_d [CHN_NUM];
   logic [CHN_NUM-1:0] dec;
   logic [CHN_NUM-1:0] ovf;
   logic [CHN_NUM-1:0] udf;

   // Ack availability sees this cycle's arriving ack with no register in between.
   always_comb begin
      for (int i = 0; i < CHN_NUM; i++) begin
         chn_bawt[i] = chn_biwt[i] | (cnt_q[i] != '0);
      end
   end

   assign all_bawt     = &chn_bawt;
   assign chn_wen_comp = ~chn_oswt | chn_bawt;
   assign dec          = (chn_bdwt | {CHN_NUM{grp_bdwt & all_bawt}}) & chn_bawt;

   always_comb begin
      for (int i = 0; i < CHN_NUM; i++) begin
         cnt_d[i] = cnt_q[i];
         ovf[i]   = 1'b0;
         udf[i]   = chn_bdwt[i] & ~chn_bawt[i];
         if (chn_biwt[i] && !dec[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ovf[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else if (dec[i] && !chn_biwt[i]) begin
            // dec without biwt implies bawt came from a non-zero count
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         for (int i = 0; i < CHN_NUM; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHN_NUM; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < CHN_NUM; i++) begin
         chn_pend_cnt[i*CW +: CW] = cnt_q[i];
      end
   end

`ifdef NVDLA_CSC_CHN_WAIT_ERR_EN
   logic [CHN_NUM-1:0] err_q;
   logic [CHN_NUM-1:0] err_d;

   // A new error event outranks a simultaneous clear.
   assign err_d = (ovf | udf) | (err_q & ~{CHN_NUM{err_clr}});

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign chn_err = err_q;
`else
   logic unused_err_sink;
   assign unused_err_sink = err_clr ^ (^ovf) ^ (^udf);
   assign chn_err         = '0;
`endif

endmodule
